dpram_stream_fifo: RTL

//  Valid/ready streaming FIFO controller that sits upstream of, and drives, a dual_port_ram instance.

---
 rtl/dpram_stream_fifo.sv | 117 +++++++++++
 1 files changed

// File: rtl/dpram_stream_fifo.sv
// Valid/ready FWFT stream FIFO controller driving an external dual-port RAM
// (port A write-only, port B read-only, 1-cycle registered read-first data).
module dpram_stream_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 3)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    level,
    output logic             ram_w_en_a,
    output logic [AW-1:0]    ram_addr_a,
    output logic [WIDTH-1:0] ram_wdata_a,
    output logic             ram_w_en_b,
    output logic [AW-1:0]    ram_addr_b,
    output logic [WIDTH-1:0] ram_wdata_b,
    input  logic [WIDTH-1:0] ram_rdata_b
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      mem_cnt_q, mem_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic [1:0]       buf_cnt_q, buf_cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] second_q, second_d;
    logic             in_ready_q, in_ready_d;
    logic [CW-1:0]    level_q, level_d;

    logic             push;
    logic             pop;
    logic             issue;
    logic [2:0]       occ_after_pop;
    logic [1:0]       buf_left;

    always_comb begin
        push          = in_valid & in_ready_q;
        pop           = (buf_cnt_q != 2'd0) & out_ready;
        // Skid occupancy once this cycle's pop and in-flight read settle; a new
        // read may only launch if that leaves a free slot for its data.
        occ_after_pop = {1'b0, buf_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
        issue         = (mem_cnt_q != '0) && (occ_after_pop < 3'd2);

        wr_ptr_d      = push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
        mem_cnt_d     = mem_cnt_q + (AW+1)'(push) - (AW+1)'(issue);
        rd_pend_d     = issue;
        in_ready_d    = (mem_cnt_d < (AW+1)'(DEPTH));

        buf_left      = buf_cnt_q - 2'(pop);
        buf_cnt_d     = buf_left + 2'(rd_pend_q);
        head_d        = head_q;
        second_d      = second_q;
        if (pop && (buf_cnt_q == 2'd2)) begin
            head_d = second_q;
        end
        if (rd_pend_q) begin
            if (buf_left == 2'd0) begin
                head_d = ram_rdata_b;
            end else begin
                second_d = ram_rdata_b;
            end
        end

        level_d       = CW'(mem_cnt_d) + CW'(rd_pend_d) + CW'(buf_cnt_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            rd_pend_q  <= 1'b0;
            buf_cnt_q  <= '0;
            head_q     <= '0;
            second_q   <= '0;
            in_ready_q <= 1'b0;
            level_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            rd_pend_q  <= rd_pend_d;
            buf_cnt_q  <= buf_cnt_d;
            head_q     <= head_d;
            second_q   <= second_d;
            in_ready_q <= in_ready_d;
            level_q    <= level_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (buf_cnt_q != 2'd0);
    assign out_data    = head_q;
    assign level       = level_q;
    assign ram_w_en_a  = push;
    assign ram_addr_a  = wr_ptr_q;
    assign ram_wdata_a = in_data;
    assign ram_w_en_b  = 1'b0;
    assign ram_addr_b  = rd_ptr_q;
    assign ram_wdata_b = '0;

    a_buf_bound : assert property (@(posedge clk) disable iff (!rst_n)
        buf_cnt_q <= 2'd2);
    a_mem_bound : assert property (@(posedge clk) disable iff (!rst_n)
        mem_cnt_q <= (AW+1)'(DEPTH));
    a_no_rw_collide : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && issue && (wr_ptr_q == rd_ptr_q)));

endmodule
